// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared states and default constants for the PDM mic capture path
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } mic_state_e;

  localparam int DEF_HALF_PERIOD = 50;
  localparam int DEF_DEC_LEN     = 64;
  localparam int DEF_SAMPLE_W    = 8;
  localparam int DEF_WARMUP_BITS = 1024;
  localparam int DEF_CNT_W       = 16;

  // Largest PCM value representable in a word of the given width
  function automatic int sat_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - enable-gated mic bit clock divider with end-of-high-phase strobe
module pdm_clk_gen #(
  parameter int HALF_PERIOD = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic mic_clk,
  output logic bit_strobe
);

  localparam int DIV_W = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);

  logic [DIV_W-1:0] count_q;
  logic             mic_clk_q;
  logic             half_end;

  assign half_end = (count_q == DIV_W'(HALF_PERIOD - 1));

  // Divider holds at zero/low while disabled so every session starts from a clean phase
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count_q   <= '0;
      mic_clk_q <= 1'b0;
    end else if (half_end) begin
      count_q   <= '0;
      mic_clk_q <= ~mic_clk_q;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  // Gating the output makes mic_clk drop in the same cycle the enable goes away
  assign mic_clk    = mic_clk_q & enable;
  assign bit_strobe = enable & half_end & mic_clk_q;

endmodule

// File: rtl/pdm_mic_capture_ctrl.sv
// rtl/pdm_mic_capture_ctrl.sv - PDM mic capture sequencer, popcount decimator and FIFO writer
module pdm_mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int DEC_LEN     = DEF_DEC_LEN,
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int WARMUP_BITS = DEF_WARMUP_BITS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    num_samples,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lrsel,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [SAMPLE_W-1:0] fifo_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int          ONES_W  = $clog2(DEC_LEN + 1);
  localparam int          BIT_W   = $clog2(DEC_LEN);
  localparam int          WARM_W  = (WARMUP_BITS < 2) ? 1 : $clog2(WARMUP_BITS);
  localparam logic [31:0] SAT_MAX = 32'(sat_max(SAMPLE_W));

  mic_state_e          state_q;
  logic [WARM_W-1:0]   warm_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [ONES_W-1:0]   ones_q;
  logic [CNT_W-1:0]    samp_cnt_q;
  logic [CNT_W-1:0]    num_q;
  logic                fifo_wr_q;
  logic [SAMPLE_W-1:0] fifo_data_q;
  logic                done_q;
  logic                overflow_q;

  logic                clk_en;
  logic                bit_strobe;
  logic [ONES_W-1:0]   ones_d;
  logic [31:0]         ones_ext;
  logic [SAMPLE_W-1:0] pcm_d;

  assign clk_en = (state_q == WARMUP) || (state_q == CAPTURE);

  pdm_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (clk_en),
    .mic_clk   (mic_clk),
    .bit_strobe(bit_strobe)
  );

  // Window popcount including the bit sampled this cycle, saturated to the PCM width
  assign ones_d   = ones_q + ONES_W'(mic_data);
  assign ones_ext = 32'(ones_d);
  assign pcm_d    = (ones_ext > SAT_MAX) ? SAT_MAX[SAMPLE_W-1:0] : ones_ext[SAMPLE_W-1:0];

  // Session sequencer and decimator; stop from any active state aborts without output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      samp_cnt_q  <= '0;
      num_q       <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      // A drop later in this block overrides the clear
      if (overflow_clr) overflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            samp_cnt_q <= '0;
            num_q      <= num_samples;
            state_q    <= (WARMUP_BITS == 0) ? CAPTURE : WARMUP;
          end
        end
        WARMUP: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (bit_strobe) begin
            if (warm_cnt_q == WARM_W'(WARMUP_BITS - 1)) state_q <= CAPTURE;
            else warm_cnt_q <= warm_cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state_q <= IDLE;
          end else if ((num_q != '0) && (samp_cnt_q == num_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (bit_strobe) begin
            if (bit_cnt_q == BIT_W'(DEC_LEN - 1)) begin
              fifo_data_q <= pcm_d;
              fifo_wr_q   <= !fifo_full;
              if (fifo_full) overflow_q <= 1'b1;
              ones_q      <= '0;
              bit_cnt_q   <= '0;
              samp_cnt_q  <= samp_cnt_q + 1'b1;
            end else begin
              ones_q    <= ones_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mic_lrsel = 1'b0;
  assign fifo_wr   = fifo_wr_q;
  assign fifo_data = fifo_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pdm_mic_capture_ctrl.sv
// tb/tb_pdm_mic_capture_ctrl.sv - directed scoreboard bench for pdm_mic_capture_ctrl
module tb_pdm_mic_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_samples = '0;
  logic        mic_data = 1'b0;
  logic        mic_clk;
  logic        mic_lrsel;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_total = 0;
  int done_total = 0;
  int done_cyc = -1;
  logic prev_mc_mon = 1'b0;

  logic [7:0] exp_q[$];
  int         wr_cycs[$];
  int         rise_q[$];

  pdm_mic_capture_ctrl #(
    .HALF_PERIOD(2),
    .DEC_LEN    (8),
    .SAMPLE_W   (8),
    .WARMUP_BITS(4),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .num_samples (num_samples),
    .mic_data    (mic_data),
    .mic_clk     (mic_clk),
    .mic_lrsel   (mic_lrsel),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on every write, done and mic_clk rise bookkeeping
  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_total++;
      wr_cycs.push_back(cyc);
      check("sb_nonempty_on_wr", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("fifo_data", fifo_data, exp_q.pop_front());
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    if (mic_clk && !prev_mc_mon) rise_q.push_back(cyc);
    prev_mc_mon = mic_clk;
  end

  task automatic pulse_start(input logic [15:0] n);
    num_samples = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int max, input bit toggle, output int end_cyc);
    logic prev_mc;
    prev_mc = mic_clk;
    end_cyc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (toggle && prev_mc && !mic_clk) mic_data = ~mic_data;
      prev_mc = mic_clk;
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
    end
    check("session_end_in_time", end_cyc != -1, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mic_clk"}, mic_clk, 0);
    check({pfx, "_mic_lrsel"}, mic_lrsel, 0);
    check({pfx, "_fifo_wr"}, fifo_wr, 0);
    check({pfx, "_fifo_data"}, fifo_data, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w0, d0, endc;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Session 1: all ones, 3 samples, timing of writes/done/mic_clk
    mic_data = 1'b1;
    repeat (3) exp_q.push_back(8'd8);
    w0 = wr_total; d0 = done_total;
    wr_cycs.delete(); rise_q.delete();
    pulse_start(16'd3);
    t0 = cyc;
    run_until_idle(300, 1'b0, endc);
    check("s1_wr_count", wr_total - w0, 3);
    check("s1_wr0_cyc", (wr_cycs.size() > 0) ? wr_cycs[0] - t0 : -1, 48);
    check("s1_wr1_cyc", (wr_cycs.size() > 1) ? wr_cycs[1] - t0 : -1, 80);
    check("s1_wr2_cyc", (wr_cycs.size() > 2) ? wr_cycs[2] - t0 : -1, 112);
    check("s1_done_count", done_total - d0, 1);
    check("s1_done_cyc", done_cyc - t0, 113);
    check("s1_idle_cyc", endc - t0, 114);
    check("s1_first_rise", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 2);
    check("s1_mic_period", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 4);
    check("s1_mic_clk_idle", mic_clk, 0);
    check("s1_sb_empty", exp_q.size(), 0);

    // Session 2: alternating bits -> half ones
    repeat (2) exp_q.push_back(8'd4);
    w0 = wr_total; d0 = done_total;
    pulse_start(16'd2);
    run_until_idle(300, 1'b1, endc);
    check("s2_wr_count", wr_total - w0, 2);
    check("s2_done_count", done_total - d0, 1);
    check("s2_sb_empty", exp_q.size(), 0);

    // Session 3: FIFO full across 2nd window end only
    mic_data = 1'b1;
    repeat (2) exp_q.push_back(8'd8);
    w0 = wr_total;
    pulse_start(16'd3);
    t0 = cyc;
    repeat (59) @(negedge clk);
    fifo_full = 1'b1;
    repeat (40) @(negedge clk);
    fifo_full = 1'b0;
    run_until_idle(300, 1'b0, endc);
    check("s3_wr_count", wr_total - w0, 2);
    check("s3_overflow_set", overflow, 1);
    repeat (3) @(negedge clk);
    check("s3_overflow_sticky", overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("s3_overflow_cleared", overflow, 0);

    // Session 3b: overflow_clr in the same cycle as a new drop
    fifo_full = 1'b1;
    w0 = wr_total;
    pulse_start(16'd1);
    repeat (47) @(negedge clk);
    check("s3b_ovf_before_drop", overflow, 0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("s3b_ovf_set_wins", overflow, 1);
    run_until_idle(100, 1'b0, endc);
    fifo_full = 1'b0;
    check("s3b_wr_count", wr_total - w0, 0);

    // Session 4: continuous mode, stop mid-window after 5 samples
    repeat (5) exp_q.push_back(8'd8);
    w0 = wr_total; d0 = done_total;
    pulse_start(16'd0);
    check("s4_ovf_kept_by_start", overflow, 1);
    repeat (189) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("s4_mic_clk_after_stop", mic_clk, 0);
    check("s4_busy_after_stop", busy, 0);
    repeat (40) @(negedge clk);
    check("s4_wr_count", wr_total - w0, 5);
    check("s4_no_done", done_total - d0, 0);
    check("s4_sb_empty", exp_q.size(), 0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("s4_overflow_cleared", overflow, 0);

    // Session 5: start during CAPTURE is ignored
    repeat (2) exp_q.push_back(8'd8);
    w0 = wr_total;
    wr_cycs.delete();
    pulse_start(16'd2);
    t0 = cyc;
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_idle(300, 1'b0, endc);
    check("s5_wr_count", wr_total - w0, 2);
    check("s5_wr0_cyc", (wr_cycs.size() > 0) ? wr_cycs[0] - t0 : -1, 48);
    check("s5_wr1_cyc", (wr_cycs.size() > 1) ? wr_cycs[1] - t0 : -1, 80);
    check("s5_idle_cyc", endc - t0, 82);

    // start & stop together in IDLE: no session
    w0 = wr_total;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_busy_now", busy, 0);
    repeat (60) @(negedge clk);
    check("ss_busy_later", busy, 0);
    check("ss_no_wr", wr_total - w0, 0);

    // Session 6: reset mid-CAPTURE, then a fresh session re-runs warmup
    fifo_full = 1'b1;
    w0 = wr_total;
    pulse_start(16'd0);
    repeat (59) @(negedge clk);
    check("s6_ovf_before_reset", overflow, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("s6_rst");
    reset = 1'b0;
    fifo_full = 1'b0;
    check("s6_no_wr", wr_total - w0, 0);
    @(negedge clk);
    exp_q.push_back(8'd8);
    d0 = done_total;
    wr_cycs.delete();
    pulse_start(16'd1);
    t0 = cyc;
    run_until_idle(300, 1'b0, endc);
    check("s6_rerun_wr_cyc", (wr_cycs.size() > 0) ? wr_cycs[0] - t0 : -1, 48);
    check("s6_done_count", done_total - d0, 1);
    check("s6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_mic_capture_ctrl.md
Name: pdm_mic_capture_ctrl

Overview:
Sequences a PDM microphone capture session for the J1 SoC audio path.
- Generates the gated mic bit clock from the system clock.
- Samples the 1-bit PDM stream and decimates it by popcount over fixed windows into PCM words.
- Pushes PCM words into the downstream mic FIFO.
- Start/stop/length come from the CPU register block; busy/done/overflow status goes back to it.

Parameters:
HALF_PERIOD, 50, clk cycles per mic_clk half-period (mic_clk period = 2*HALF_PERIOD); min 2
DEC_LEN, 64, PDM bits per PCM sample (decimation window); min 2
SAMPLE_W, 8, PCM word width; ones count saturates at 2^SAMPLE_W-1
WARMUP_BITS, 1024, bit strobes discarded after start (mic settling); 0 = no warmup
CNT_W, 16, width of sample-length counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begin capture session
stop  in  1  one-cycle pulse, abort session
num_samples  in  CNT_W  samples per session, latched at start; 0 = continuous until stop
mic_data  in  1  PDM data from microphone (already synchronised)
mic_clk  out  1  bit clock to microphone
mic_lrsel  out  1  channel select, constant 0
fifo_full  in  1  downstream FIFO full
fifo_wr  out  1  one-cycle write strobe
fifo_data  out  SAMPLE_W  PCM word, valid with fifo_wr
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
overflow  out  1  sticky, sample dropped on full FIFO
overflow_clr  in  1  clears overflow

Behaviour:
- Reset: state IDLE, mic_clk=0, div count=0, fifo_wr=0, fifo_data=0, done=0, busy=0, overflow=0, all counters 0.
- States: IDLE -> (start & !stop) -> WARMUP (or CAPTURE if WARMUP_BITS=0) -> after WARMUP_BITS strobes -> CAPTURE -> last sample written -> DONE -> next cycle -> IDLE. stop in any non-IDLE state -> IDLE next cycle.
- start while busy: ignored. start & stop same cycle in IDLE: no session.
- Divider: runs only outside IDLE/DONE; on leaving IDLE count=0, mic_clk=0. Each clk: if count==HALF_PERIOD-1, count<=0 and mic_clk toggles; otherwise count+1. First mic_clk rise is HALF_PERIOD cycles after the state leaves IDLE.
- bit_strobe: one clk, when count==HALF_PERIOD-1 and mic_clk==1 (end of high phase). mic_data is sampled in that cycle.
- WARMUP: counts strobes and discards data.
- CAPTURE: per strobe, ones += mic_data and bitcnt += 1. On the DEC_LEN-th strobe:
  - fifo_data <= min(ones incl. current bit, 2^SAMPLE_W-1).
  - fifo_wr <= !fifo_full, registered: pulses the cycle after the strobe.
  - ones and bitcnt cleared; sample count increments.
- Overflow: fifo_full at window end drops the sample and sets overflow. A dropped sample still counts toward num_samples (real-time stream). Set and overflow_clr in the same cycle: set wins. overflow is not cleared by start.
- Completion: num_samples!=0 and sample count reaches num_samples -> DONE. done pulses high during DONE, in the cycle after the last fifo_wr slot. mic_clk is forced 0 in DONE and IDLE.
- Stop/abort: partial window discarded, no fifo_wr, no done, mic_clk forced 0 in the next cycle.
- Continuous mode counter: wraps silently.
- Reset mid-session: identical to power-on reset.

Decomposition:
- Shared package mic_pkg: state enum (IDLE, WARMUP, CAPTURE, DONE) and default constants (HALF_PERIOD, DEC_LEN, SAMPLE_W).
- One sub-module pdm_clk_gen (enable, HALF_PERIOD) -> mic_clk and bit_strobe. This is the enable-gated divider with sample strobe.
- Sequencer FSM and decimator stay in the top module.

Test Plan:
All scenarios use HALF_PERIOD=2, DEC_LEN=8, WARMUP_BITS=4.
- mic_data=1, num_samples=3, start -> 4 strobes without writes, then exactly 3 fifo_wr with fifo_data=8 spaced 32 clks apart, done one cycle after the window end, busy low afterwards, mic_clk period 4 clks.
- mic_data toggles each strobe, num_samples=2 -> fifo_data=4 twice, then done.
- fifo_full=1 for the 2nd window, num_samples=3 -> writes only for the 1st and 3rd windows, overflow=1 until overflow_clr. overflow_clr coincident with a new drop leaves overflow=1.
- num_samples=0, stop issued mid-window after 5 samples -> 5 writes, no partial write, no done, mic_clk=0 and busy=0 within 1 cycle.
- start during CAPTURE is ignored (sample count unaffected). start & stop in the same cycle in IDLE -> stays IDLE.
- reset asserted mid-CAPTURE -> all outputs at reset values next cycle. A new start then re-runs warmup from zero.
